serial_mul: RTL and testbench

//  Iterative shift-add 32x32 multiplier for MULT/MULTU: the inverse-operation companion of the serial divider.

---
 rtl/serial_mul_if.sv | 23 ++
 rtl/serial_mul.sv | 112 +++++++++++
 tb/tb_serial_mul.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/serial_mul_if.sv
// Start/finish handshake bundle between the EX stage and the serial multiplier.
// The master side issues operands; the slave side (the multiplier) returns the product.
interface serial_mul_if #(
  parameter int WIDTH = 32
);
  logic             start_i;
  logic             if_signed_i;
  logic [WIDTH-1:0] multiplicand_i;
  logic [WIDTH-1:0] multiplier_i;
  logic [WIDTH-1:0] product_hi_o;
  logic [WIDTH-1:0] product_lo_o;
  logic             finish_o;

  modport master (
    output start_i, if_signed_i, multiplicand_i, multiplier_i,
    input  product_hi_o, product_lo_o, finish_o
  );

  modport slave (
    input  start_i, if_signed_i, multiplicand_i, multiplier_i,
    output product_hi_o, product_lo_o, finish_o
  );
endinterface

// File: rtl/serial_mul.sv
// Iterative shift-add multiplier for MULT/MULTU, one product bit per cycle.
// Optional SERIAL_MUL_ZERO_BYPASS_EN: a zero operand skips straight to FINISH.
//
// state   | meaning
// IDLE    | waiting for start_i; latches operand magnitudes and result sign
// ONGOING | 32 shift-add iterations, counter 0..31
// FINISH  | applies sign, registers product, pulses finish_o
module serial_mul #(
  parameter int WIDTH = 32
) (
  input  logic        clk,
  input  logic        rst,
  serial_mul_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ONGOING = 2'd1,
    FINISH  = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    counter;
  logic [WIDTH-1:0] mcand, mplier;
  logic [WIDTH-1:0] acc_hi, acc_lo;
  logic             neg;
  logic [WIDTH-1:0] a_abs, b_abs;
  logic [WIDTH:0]   sum;
  logic [2*WIDTH-1:0] acc_full, prod_nxt;
  logic             zero_op;

  assign a_abs = (bus.if_signed_i && bus.multiplicand_i[WIDTH-1]) ? -bus.multiplicand_i
                                                                 : bus.multiplicand_i;
  assign b_abs = (bus.if_signed_i && bus.multiplier_i[WIDTH-1]) ? -bus.multiplier_i
                                                               : bus.multiplier_i;

`ifdef SERIAL_MUL_ZERO_BYPASS_EN
  assign zero_op = (bus.multiplicand_i == '0) || (bus.multiplier_i == '0);
`else
  assign zero_op = 1'b0;
`endif

  // 33-bit add keeps the carry that shifts into acc_hi's MSB
  assign sum      = {1'b0, acc_hi} + (mplier[0] ? {1'b0, mcand} : '0);
  assign acc_full = {acc_hi, acc_lo};
  assign prod_nxt = neg ? (~acc_full + 1'b1) : acc_full;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (!bus.start_i) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    state_nxt = zero_op ? FINISH : ONGOING;
        ONGOING: if (counter == CW'(WIDTH - 1)) state_nxt = FINISH;
        FINISH:  state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      counter          <= '0;
      mcand            <= '0;
      mplier           <= '0;
      acc_hi           <= '0;
      acc_lo           <= '0;
      neg              <= 1'b0;
      bus.finish_o     <= 1'b0;
      bus.product_hi_o <= '0;
      bus.product_lo_o <= '0;
    end else begin
      bus.finish_o <= 1'b0;
      if (!bus.start_i) begin
        counter <= '0;
        acc_hi  <= '0;
        acc_lo  <= '0;
      end else begin
        case (state)
          IDLE: begin
            mcand   <= a_abs;
            mplier  <= b_abs;
            neg     <= zero_op ? 1'b0
                               : (bus.if_signed_i &
                                  (bus.multiplicand_i[WIDTH-1] ^ bus.multiplier_i[WIDTH-1]));
            acc_hi  <= '0;
            acc_lo  <= '0;
            counter <= '0;
          end
          ONGOING: begin
            acc_hi  <= sum[WIDTH:1];
            acc_lo  <= {sum[0], acc_lo[WIDTH-1:1]};
            mplier  <= mplier >> 1;
            counter <= counter + CW'(1);
          end
          FINISH: begin
            {bus.product_hi_o, bus.product_lo_o} <= prod_nxt;
            bus.finish_o <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_serial_mul.sv
// Randomized scoreboard bench for serial_mul: an arithmetic reference model queues
// expected products, a negedge monitor pops and compares on every finish_o.
module tb_serial_mul;
  logic clk = 1'b0;
  logic rst = 1'b1;

  serial_mul_if #(.WIDTH(32)) bus ();
  serial_mul #(.WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic [63:0] exp_q[$];
  logic [63:0] last_prod = '0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic [63:0] model(input bit sg, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ea, eb;
    ea = sg ? {{32{a[31]}}, a} : {32'b0, a};
    eb = sg ? {{32{b[31]}}, b} : {32'b0, b};
    return ea * eb;
  endfunction

  function automatic int exp_latency(input logic [31:0] a, input logic [31:0] b);
`ifdef SERIAL_MUL_ZERO_BYPASS_EN
    if (a == 0 || b == 0) return 2;
`endif
    return 34;
  endfunction

  always @(negedge clk) begin
    if (!rst && bus.finish_o) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_finish", {bus.product_hi_o, bus.product_lo_o}, 64'hx);
      end else begin
        chk("product", {bus.product_hi_o, bus.product_lo_o}, exp_q.pop_front());
      end
    end
  end

  task automatic wait_finish(input int budget, output int edges);
    edges = 0;
    do begin
      @(posedge clk); #1;
      edges++;
    end while (!bus.finish_o && edges < budget);
    if (!bus.finish_o) begin
      n_cmp++; n_bad++;
      $display("FAIL finish_timeout: got no finish_o after %0d edges", edges);
    end
  endtask

  task automatic run_op(input bit sg, input logic [31:0] a, input logic [31:0] b);
    int edges;
    logic [63:0] e;
    @(negedge clk);
    bus.if_signed_i    = sg;
    bus.multiplicand_i = a;
    bus.multiplier_i   = b;
    bus.start_i        = 1'b1;
    e = model(sg, a, b);
    exp_q.push_back(e);
    edges = 0;
    do begin
      @(posedge clk); #1;
      edges++;
      if (edges == 5) begin
        bus.multiplicand_i = $urandom;
        bus.multiplier_i   = $urandom;
        bus.if_signed_i    = ~sg;
      end
    end while (!bus.finish_o && edges < 60);
    chk("latency", 64'(edges), 64'(exp_latency(a, b)));
    @(negedge clk);
    bus.start_i = 1'b0;
    @(posedge clk); #1;
    chk("pulse_width", 64'(bus.finish_o), 64'd0);
    last_prod = e;
  endtask

  initial begin
    int edges;
    logic [31:0] ra, rb;
    bus.start_i = 1'b0;
    bus.if_signed_i = 1'b0;
    bus.multiplicand_i = '0;
    bus.multiplier_i = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_product", {bus.product_hi_o, bus.product_lo_o}, 64'd0);
    chk("reset_finish", 64'(bus.finish_o), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    run_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk("t1_value", {bus.product_hi_o, bus.product_lo_o}, 64'hFFFF_FFFE_0000_0001);
    run_op(1'b1, 32'hFFFF_FFFD, 32'd7);
    chk("t2_signed", {bus.product_hi_o, bus.product_lo_o}, 64'hFFFF_FFFF_FFFF_FFEB);
    run_op(1'b0, 32'hFFFF_FFFD, 32'd7);
    chk("t2_unsigned", {bus.product_hi_o, bus.product_lo_o}, 64'h0000_0006_FFFF_FFEB);
    run_op(1'b1, 32'h8000_0000, 32'h8000_0000);
    chk("t3_minmin", {bus.product_hi_o, bus.product_lo_o}, 64'h4000_0000_0000_0000);
    run_op(1'b1, 32'h8000_0000, 32'd1);
    chk("t3_min_one", {bus.product_hi_o, bus.product_lo_o}, 64'hFFFF_FFFF_8000_0000);

    // abort at counter=10: no finish, outputs keep previous product
    @(negedge clk);
    bus.if_signed_i = 1'b0; bus.multiplicand_i = 32'd12345; bus.multiplier_i = 32'd999;
    bus.start_i = 1'b1;
    repeat (11) @(posedge clk);
    @(negedge clk);
    bus.start_i = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    chk("abort_hold", {bus.product_hi_o, bus.product_lo_o}, last_prod);
    run_op(1'b0, 32'd6, 32'd7);
    chk("abort_restart", {bus.product_hi_o, bus.product_lo_o}, 64'd42);

    // synchronous reset in the middle of an operation
    @(negedge clk);
    bus.if_signed_i = 1'b1; bus.multiplicand_i = 32'h1234_5678; bus.multiplier_i = 32'hDEAD_BEEF;
    bus.start_i = 1'b1;
    repeat (21) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_product", {bus.product_hi_o, bus.product_lo_o}, 64'd0);
    chk("rst_finish", 64'(bus.finish_o), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    bus.start_i = 1'b0;
    last_prod = '0;
    run_op(1'b1, 32'hFFFF_FF00, 32'd300);

    // zero operands
    run_op(1'b0, 32'd0, 32'h1234);
    chk("zero_a", {bus.product_hi_o, bus.product_lo_o}, 64'd0);
    run_op(1'b1, 32'hFFFF_FFFF, 32'd0);

    // start held across finish: second run uses the current operands
    @(negedge clk);
    bus.if_signed_i = 1'b1; bus.multiplicand_i = 32'hFFFF_FFF0; bus.multiplier_i = 32'd3;
    bus.start_i = 1'b1;
    exp_q.push_back(model(1'b1, 32'hFFFF_FFF0, 32'd3));
    exp_q.push_back(model(1'b1, 32'hFFFF_FFF0, 32'd3));
    wait_finish(60, edges);
    chk("b2b_first_lat", 64'(edges), 64'd34);
    wait_finish(60, edges);
    chk("b2b_second_lat", 64'(edges), 64'd34);
    @(negedge clk);
    bus.start_i = 1'b0;

    for (int i = 0; i < 20; i++) begin
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
      if ($urandom_range(0, 9) == 0) rb = 32'd0;
      run_op(1'($urandom_range(0, 1)), ra, rb);
    end

    repeat (4) @(posedge clk);
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end
endmodule
